// File: rtl/rf_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler: fixed register
// addresses, the grant-source encoding and the UART FIFO entry format.
package rf_sched_pkg;

  localparam logic [4:0] K0_ADDR   = 5'd26;
  localparam logic [4:0] ZERO_ADDR = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_EXC  = 2'd2,
    SRC_UART = 2'd3
  } grant_src_e;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } uart_entry_t;

  // Destination register for a buffered UART byte.
  function automatic logic [4:0] uart_dest(input logic       flag,
                                           input logic [4:0] reg1,
                                           input logic [4:0] reg2);
    return flag ? reg2 : reg1;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Bundle of requester inputs, register-file write port and status outputs.
// The master side is the surrounding pipeline/UART logic; the slave side
// is the scheduler. The pipe_hold signal exists only when
// RF_SCHED_STARVE_EN is defined.
interface rf_write_scheduler_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          exc_req;
  logic [31:0]   exc_data;
  logic          uart_valid;
  logic          uart_flag;
  logic [7:0]    uart_byte;

  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [31:0]   rf_data;
  logic          exc_pending;
  logic [LW-1:0] fifo_level;
  logic          uart_overflow;
  logic [7:0]    result_data;
  logic          result_valid;
`ifdef RF_SCHED_STARVE_EN
  logic          pipe_hold;
`endif

`ifdef RF_SCHED_STARVE_EN
  modport master (
    output wb_we, wb_addr, wb_data, exc_req, exc_data,
           uart_valid, uart_flag, uart_byte,
    input  rf_we, rf_addr, rf_data, exc_pending, fifo_level,
           uart_overflow, result_data, result_valid, pipe_hold
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, exc_req, exc_data,
           uart_valid, uart_flag, uart_byte,
    output rf_we, rf_addr, rf_data, exc_pending, fifo_level,
           uart_overflow, result_data, result_valid, pipe_hold
  );
`else
  modport master (
    output wb_we, wb_addr, wb_data, exc_req, exc_data,
           uart_valid, uart_flag, uart_byte,
    input  rf_we, rf_addr, rf_data, exc_pending, fifo_level,
           uart_overflow, result_data, result_valid
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, exc_req, exc_data,
           uart_valid, uart_flag, uart_byte,
    output rf_we, rf_addr, rf_data, exc_pending, fifo_level,
           uart_overflow, result_data, result_valid
  );
`endif

endinterface

// File: rtl/rf_write_scheduler_fifo.sv
// Small synchronous FIFO buffering received UART bytes until the write
// port is free. A push while full is accepted only when a pop happens in
// the same cycle; the caller detects drops from full/pop itself.
module rf_sched_fifo
  import rf_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  uart_entry_t   wr_data,
  output uart_entry_t   rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  uart_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Entry storage; contents past the level are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Single-port register-file write scheduler. WB writeback always wins the
// port; a pending $k0 save goes next, then the head of the UART byte FIFO.
// WB writes to RESULT_REG are captured for UART transmit.
// Optional starvation guard: define RF_SCHED_STARVE_EN to add pipe_hold.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [4:0] UART_REG1    = 5'd4,
  parameter logic [4:0] UART_REG2    = 5'd5,
  parameter logic [4:0] RESULT_REG   = 5'd2,
  parameter int         STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  rf_write_scheduler_if.slave bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (STARVE_LIMIT < 1)) begin : g_param_check
    $error("rf_write_scheduler: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  grant_src_e    grant_src;
  logic          wb_ok;
  logic          exc_pending_q;
  logic [31:0]   exc_data_q;
  logic          uart_overflow_q;
  logic [7:0]    result_data_q;
  logic          result_valid_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  uart_entry_t   fifo_head;
  uart_entry_t   fifo_wr;

  // A WB write to $0 carries no data, so it leaves the slot to others.
  assign wb_ok = bus.wb_we && (bus.wb_addr != ZERO_ADDR);

  // Fixed-priority arbitration; nothing is granted while in reset.
  always_comb begin
    grant_src = SRC_NONE;
    if (!reset) begin
      if (wb_ok) begin
        grant_src = SRC_WB;
      end else if (exc_pending_q) begin
        grant_src = SRC_EXC;
      end else if (!fifo_empty) begin
        grant_src = SRC_UART;
      end
    end
  end

  // Drive the register-file write port from the winning source.
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = ZERO_ADDR;
    bus.rf_data = '0;
    case (grant_src)
      SRC_WB: begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = bus.wb_addr;
        bus.rf_data = bus.wb_data;
      end
      SRC_EXC: begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = K0_ADDR;
        bus.rf_data = exc_data_q;
      end
      SRC_UART: begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = uart_dest(fifo_head.flag, UART_REG1, UART_REG2);
        bus.rf_data = {24'b0, fifo_head.data};
      end
      default: begin
        bus.rf_we   = 1'b0;
        bus.rf_addr = ZERO_ADDR;
        bus.rf_data = '0;
      end
    endcase
  end

  assign fifo_push    = bus.uart_valid && !reset;
  assign fifo_pop     = (grant_src == SRC_UART);
  assign fifo_wr.flag = bus.uart_flag;
  assign fifo_wr.data = bus.uart_byte;

  rf_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // $k0 save latch: a new request always wins over clearing, so a request
  // coinciding with a grant re-arms with the fresh PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_pending_q <= 1'b0;
      exc_data_q    <= '0;
    end else if (bus.exc_req) begin
      exc_pending_q <= 1'b1;
      exc_data_q    <= bus.exc_data;
    end else if (grant_src == SRC_EXC) begin
      exc_pending_q <= 1'b0;
    end
  end

  // Sticky flag for a byte dropped because the FIFO was full with no pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_overflow_q <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      uart_overflow_q <= 1'b1;
    end
  end

  // Capture the low byte of granted WB writes to the result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if ((grant_src == SRC_WB) && (bus.wb_addr == RESULT_REG)) begin
        result_data_q  <= bus.wb_data[7:0];
        result_valid_q <= 1'b1;
      end
    end
  end

  assign bus.exc_pending   = exc_pending_q;
  assign bus.fifo_level    = fifo_level;
  assign bus.uart_overflow = uart_overflow_q;
  assign bus.result_data   = result_data_q;
  assign bus.result_valid  = result_valid_q;

`ifdef RF_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_left;
  logic          pipe_hold_q;
  logic          lower_req;
  logic          lower_grant;
  logic          lower_denied;

  assign lower_req    = exc_pending_q || !fifo_empty;
  assign lower_grant  = (grant_src == SRC_EXC) || (grant_src == SRC_UART);
  assign lower_denied = lower_req && !lower_grant && !reset;

  // Down-counter of denied cycles left before the pipeline is held for
  // one cycle; the hold cycle lets the waiting requester through.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_left <= SW'(STARVE_LIMIT);
      pipe_hold_q <= 1'b0;
    end else begin
      pipe_hold_q <= 1'b0;
      if (lower_grant) begin
        starve_left <= SW'(STARVE_LIMIT);
      end else if (lower_denied) begin
        if (starve_left == SW'(1)) begin
          pipe_hold_q <= 1'b1;
          starve_left <= SW'(STARVE_LIMIT);
        end else begin
          starve_left <= starve_left - SW'(1);
        end
      end
    end
  end

  assign bus.pipe_hold = pipe_hold_q;
`endif

endmodule
